// File: rtl/despachante_terminais.sv
// Ticket dispatcher: issues numbered tickets into a counted queue
// and calls them in order to whichever enabled terminal is free.
module despachante_terminais #(
  parameter int W_SENHA  = 8,
  parameter int W_FILA   = 4,
  parameter int MAX_FILA = 15
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               TERMINAL1,
  input  logic               TERMINAL2,
  input  logic               NOVA_SENHA,
  input  logic               FIM1,
  input  logic               FIM2,
  output logic               EMITIU,
  output logic               REJEITADA,
  output logic [W_SENHA-1:0] SENHA_EMITIDA,
  output logic               CHAMA1,
  output logic               CHAMA2,
  output logic [W_SENHA-1:0] SENHA_CHAMADA,
  output logic               OCUPADO1,
  output logic               OCUPADO2,
  output logic [W_FILA-1:0]  FILA,
  output logic               FILA_VAZIA,
  output logic               FILA_CHEIA
);

  typedef enum logic [1:0] {
    DESLIGADO = 2'd0,
    LIVRE     = 2'd1,
    ATENDENDO = 2'd2
  } estado_t;

  localparam logic [W_FILA-1:0] L_MAX = W_FILA'(MAX_FILA);

  estado_t r_est1, r_est2;
  estado_t w_prox1, w_prox2;

  logic [W_SENHA-1:0] r_prox_emit;
  logic [W_SENHA-1:0] r_prox_chama;
  logic [W_SENHA-1:0] r_senha_emitida;
  logic [W_SENHA-1:0] r_senha_chamada;
  logic [W_FILA-1:0]  r_fila;
  logic               r_emitiu;
  logic               r_rejeitada;
  logic               r_chama1;
  logic               r_chama2;
  logic               r_rr;

  logic w_cheia;
  logic w_vazia;
  logic w_emite;
  logic w_rejeita;
  logic w_eleg1;
  logic w_eleg2;
  logic w_ganha1;
  logic w_ganha2;
  logic w_chama;

  // Issue/refuse and dispatch decisions from registered state
  always_comb begin
    w_cheia   = (r_fila == L_MAX);
    w_vazia   = (r_fila == '0);
    w_emite   = NOVA_SENHA && !w_cheia;
    w_rejeita = NOVA_SENHA && w_cheia;
    w_eleg1   = (r_est1 == LIVRE) && TERMINAL1 && !w_vazia;
    w_eleg2   = (r_est2 == LIVRE) && TERMINAL2 && !w_vazia;
    w_ganha1  = w_eleg1 && (!w_eleg2 || !r_rr);
    w_ganha2  = w_eleg2 && (!w_eleg1 || r_rr);
    w_chama   = w_ganha1 || w_ganha2;
  end

  // Terminal next-state; disabling a free terminal beats calling it
  always_comb begin
    w_prox1 = r_est1;
    w_prox2 = r_est2;
    unique case (r_est1)
      DESLIGADO: if (TERMINAL1) w_prox1 = LIVRE;
      LIVRE: begin
        if (!TERMINAL1)    w_prox1 = DESLIGADO;
        else if (w_ganha1) w_prox1 = ATENDENDO;
      end
      ATENDENDO: begin
        if (FIM1) w_prox1 = TERMINAL1 ? LIVRE : DESLIGADO;
      end
      default: w_prox1 = DESLIGADO;
    endcase
    unique case (r_est2)
      DESLIGADO: if (TERMINAL2) w_prox2 = LIVRE;
      LIVRE: begin
        if (!TERMINAL2)    w_prox2 = DESLIGADO;
        else if (w_ganha2) w_prox2 = ATENDENDO;
      end
      ATENDENDO: begin
        if (FIM2) w_prox2 = TERMINAL2 ? LIVRE : DESLIGADO;
      end
      default: w_prox2 = DESLIGADO;
    endcase
  end

  // Terminal state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_est1 <= DESLIGADO;
      r_est2 <= DESLIGADO;
    end else begin
      r_est1 <= w_prox1;
      r_est2 <= w_prox2;
    end
  end

  // Ticket counters, queue occupancy, pulses and round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prox_emit     <= '0;
      r_prox_chama    <= '0;
      r_senha_emitida <= '0;
      r_senha_chamada <= '0;
      r_fila          <= '0;
      r_emitiu        <= 1'b0;
      r_rejeitada     <= 1'b0;
      r_chama1        <= 1'b0;
      r_chama2        <= 1'b0;
      r_rr            <= 1'b0;
    end else begin
      r_emitiu    <= w_emite;
      r_rejeitada <= w_rejeita;
      r_chama1    <= w_ganha1;
      r_chama2    <= w_ganha2;
      if (w_emite) begin
        r_senha_emitida <= r_prox_emit;
        r_prox_emit     <= r_prox_emit + W_SENHA'(1);
      end
      if (w_chama) begin
        r_senha_chamada <= r_prox_chama;
        r_prox_chama    <= r_prox_chama + W_SENHA'(1);
      end
      if (w_ganha1)      r_rr <= 1'b1;
      else if (w_ganha2) r_rr <= 1'b0;
      if (w_emite && !w_chama)      r_fila <= r_fila + W_FILA'(1);
      else if (!w_emite && w_chama) r_fila <= r_fila - W_FILA'(1);
    end
  end

  assign EMITIU        = r_emitiu;
  assign REJEITADA     = r_rejeitada;
  assign SENHA_EMITIDA = r_senha_emitida;
  assign CHAMA1        = r_chama1;
  assign CHAMA2        = r_chama2;
  assign SENHA_CHAMADA = r_senha_chamada;
  assign OCUPADO1      = (r_est1 == ATENDENDO);
  assign OCUPADO2      = (r_est2 == ATENDENDO);
  assign FILA          = r_fila;
  assign FILA_VAZIA    = w_vazia;
  assign FILA_CHEIA    = w_cheia;

endmodule

// File: tb/tb_despachante_terminais.sv
// Scoreboard bench for despachante_terminais: expected issues,
// refusals and calls are queued by stimulus and popped by a monitor.
module tb_despachante_terminais;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TERMINAL1 = 1'b0;
  logic       TERMINAL2 = 1'b0;
  logic       NOVA_SENHA = 1'b0;
  logic       FIM1 = 1'b0;
  logic       FIM2 = 1'b0;
  logic       EMITIU, REJEITADA, CHAMA1, CHAMA2;
  logic [7:0] SENHA_EMITIDA, SENHA_CHAMADA;
  logic       OCUPADO1, OCUPADO2, FILA_VAZIA, FILA_CHEIA;
  logic [3:0] FILA;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q_emit[$];
  int         q_term[$];
  logic [7:0] q_cham[$];
  int         q_rej[$];
  logic [7:0] tb_emit;

  despachante_terminais #(
    .W_SENHA(8), .W_FILA(4), .MAX_FILA(15)
  ) dut (
    .CLK(CLK), .RST(RST),
    .TERMINAL1(TERMINAL1), .TERMINAL2(TERMINAL2),
    .NOVA_SENHA(NOVA_SENHA), .FIM1(FIM1), .FIM2(FIM2),
    .EMITIU(EMITIU), .REJEITADA(REJEITADA),
    .SENHA_EMITIDA(SENHA_EMITIDA),
    .CHAMA1(CHAMA1), .CHAMA2(CHAMA2),
    .SENHA_CHAMADA(SENHA_CHAMADA),
    .OCUPADO1(OCUPADO1), .OCUPADO2(OCUPADO2),
    .FILA(FILA), .FILA_VAZIA(FILA_VAZIA), .FILA_CHEIA(FILA_CHEIA)
  );

  always #5 CLK = ~CLK;

  // Monitor: pops expectations whenever the DUT presents a pulse
  always @(negedge CLK) begin
    logic [7:0] e;
    int         t;
    if (EMITIU) begin
      n_checks++;
      if (q_emit.size() == 0) begin
        n_errors++;
        $display("FAIL emit_unexpected got %0d required none", SENHA_EMITIDA);
      end else begin
        e = q_emit.pop_front();
        if (SENHA_EMITIDA !== e) begin
          n_errors++;
          $display("FAIL emit_num got %0d required %0d", SENHA_EMITIDA, e);
        end
      end
    end
    if (REJEITADA) begin
      n_checks++;
      if (q_rej.size() == 0) begin
        n_errors++;
        $display("FAIL reject_unexpected got 1 required 0");
      end else begin
        void'(q_rej.pop_front());
      end
    end
    if (CHAMA1 || CHAMA2) begin
      n_checks++;
      t = CHAMA1 ? 1 : 2;
      if (CHAMA1 && CHAMA2) begin
        n_errors++;
        $display("FAIL call_both got 2 calls required 1");
      end else if (q_term.size() == 0) begin
        n_errors++;
        $display("FAIL call_unexpected term %0d num %0d required none", t, SENHA_CHAMADA);
      end else begin
        e = q_cham.pop_front();
        if (t != q_term[0] || SENHA_CHAMADA !== e) begin
          n_errors++;
          $display("FAIL call got term %0d num %0d required term %0d num %0d",
                   t, SENHA_CHAMADA, q_term[0], e);
        end
        void'(q_term.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tb_emit = 8'd0;
  endtask

  task automatic nova(input bit aceita);
    if (aceita) begin
      q_emit.push_back(tb_emit);
      tb_emit = tb_emit + 8'd1;
    end else begin
      q_rej.push_back(1);
    end
    NOVA_SENHA = 1'b1;
    tick();
    NOVA_SENHA = 1'b0;
  endtask

  task automatic espera_chamada(input int t, input logic [7:0] s);
    q_term.push_back(t);
    q_cham.push_back(s);
  endtask

  task automatic fim(input int t);
    if (t == 1) FIM1 = 1'b1;
    else        FIM2 = 1'b1;
    tick();
    FIM1 = 1'b0;
    FIM2 = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_emitida"}, int'(SENHA_EMITIDA), 0);
    chk({nm, "_chamada"}, int'(SENHA_CHAMADA), 0);
    chk({nm, "_fila"}, int'(FILA), 0);
    chk({nm, "_vazia"}, int'(FILA_VAZIA), 1);
    chk({nm, "_ocup"}, int'({OCUPADO1, OCUPADO2}), 0);
    chk({nm, "_pulsos"}, int'({EMITIU, REJEITADA, CHAMA1, CHAMA2}), 0);
  endtask

  initial begin
    tb_emit = 8'd0;
    do_reset();
    chk_zero("reset");
    chk("reset_cheia", int'(FILA_CHEIA), 0);

    // Single terminal, three tickets
    TERMINAL1 = 1'b1;
    tick();
    espera_chamada(1, 8'd0);
    nova(1); nova(1); nova(1);
    chk("t1_fila_pico", int'(FILA), 2);
    chk("t1_ocup1", int'(OCUPADO1), 1);
    espera_chamada(1, 8'd1);
    fim(1);
    tick();
    chk("t1_fila_1", int'(FILA), 1);
    espera_chamada(1, 8'd2);
    fim(1);
    tick();
    chk("t1_fila_0", int'(FILA), 0);
    chk("t1_vazia", int'(FILA_VAZIA), 1);
    fim(1);
    chk("t1_livre", int'(OCUPADO1), 0);

    // Two terminals, round-robin from reset
    TERMINAL1 = 1'b0;
    do_reset();
    repeat (4) nova(1);
    chk("rr_fila4", int'(FILA), 4);
    espera_chamada(1, 8'd0);
    espera_chamada(2, 8'd1);
    TERMINAL1 = 1'b1;
    TERMINAL2 = 1'b1;
    tick(3);
    chk("rr_ocup", int'({OCUPADO1, OCUPADO2}), 3);
    chk("rr_fila2", int'(FILA), 2);
    espera_chamada(1, 8'd2);
    fim(1);
    tick();
    espera_chamada(2, 8'd3);
    fim(2);
    tick();
    chk("rr_fila0", int'(FILA), 0);
    fim(1);
    fim(2);

    // Fill the queue, refuse, then call while full
    TERMINAL1 = 1'b0;
    TERMINAL2 = 1'b0;
    do_reset();
    repeat (15) nova(1);
    tick();
    chk("cheia_fila", int'(FILA), 15);
    chk("cheia_flag", int'(FILA_CHEIA), 1);
    nova(0);
    tick();
    chk("rej_emitida", int'(SENHA_EMITIDA), 14);
    chk("rej_fila", int'(FILA), 15);
    TERMINAL1 = 1'b1;
    tick();
    espera_chamada(1, 8'd0);
    nova(0);
    tick();
    chk("cheia_chama_fila", int'(FILA), 14);

    // Disable terminal 2 mid-service
    espera_chamada(2, 8'd1);
    TERMINAL2 = 1'b1;
    tick(2);
    chk("t2_ocup", int'(OCUPADO2), 1);
    TERMINAL2 = 1'b0;
    tick();
    chk("t2_sem_abort", int'(OCUPADO2), 1);
    fim(2);
    chk("t2_deslig", int'(OCUPADO2), 0);
    tick(3);
    chk("t2_fila", int'(FILA), 13);

    // Wrap-around through one terminal
    TERMINAL1 = 1'b0;
    TERMINAL2 = 1'b0;
    do_reset();
    TERMINAL1 = 1'b1;
    tick();
    for (int i = 0; i < 260; i++) begin
      espera_chamada(1, 8'(i));
      nova(1);
      tick();
      fim(1);
    end
    chk("wrap_emitida", int'(SENHA_EMITIDA), 3);
    chk("wrap_chamada", int'(SENHA_CHAMADA), 3);

    // Reset in the middle of service
    espera_chamada(1, 8'd4);
    nova(1);
    tick();
    nova(1);
    nova(1);
    chk("mid_ocup", int'(OCUPADO1), 1);
    chk("mid_fila", int'(FILA), 2);
    TERMINAL1 = 1'b0;
    do_reset();
    chk_zero("mid_reset");

    tick(3);
    chk("sb_emit_vazio", q_emit.size(), 0);
    chk("sb_call_vazio", q_term.size(), 0);
    chk("sb_rej_vazio", q_rej.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
